// File: rtl/alu_operand_sequencer.sv
// Operand/opcode sequencer for the 4-bit lab ALU: captures A, B and opcode on
// successive button presses, registers the ALU result and counts operations.
module alu_operand_sequencer #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               step_in,
    input  logic               chain,
    input  logic [WIDTH-1:0]   alu_result,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    output logic [2:0]         opcode,
    output logic [WIDTH-1:0]   result,
    output logic               done,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   step_q;
    logic   step_pulse;
    logic   load_a;
    logic   load_b;
    logic   load_op;
    logic   capture;
    logic   reuse_result;

    // A held button produces a single pulse on its rising level.
    assign step_pulse = step_in & ~step_q;
    assign state      = state_q;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= S_A;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_in;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_a       = 1'b0;
        load_b       = 1'b0;
        load_op      = 1'b0;
        capture      = 1'b0;
        reuse_result = 1'b0;
        case (state_q)
            S_A: begin
                if (step_pulse) begin
                    load_a  = 1'b1;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (step_pulse) begin
                    load_b  = 1'b1;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (step_pulse) begin
                    load_op = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Pulses arriving here are deliberately dropped.
                capture = 1'b1;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (step_pulse) begin
                    if (chain) begin
                        reuse_result = 1'b1;
                        state_d      = S_B;
                    end else begin
                        state_d = S_A;
                    end
                end
            end
            default: state_d = S_A;
        endcase
    end

    // Operands only move on their own capture edges, so ALU inputs are stable in S_EXEC.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            op_a     <= '0;
            op_b     <= '0;
            opcode   <= '0;
            result   <= '0;
            done     <= 1'b0;
            op_count <= '0;
        end else begin
            done <= capture;
            if (load_a) begin
                op_a <= data_in;
            end else if (reuse_result) begin
                op_a <= result;
            end
            if (load_b) begin
                op_b <= data_in;
            end
            if (load_op) begin
                opcode <= data_in[2:0];
            end
            if (capture) begin
                result   <= alu_result;
                op_count <= op_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized bench for alu_operand_sequencer with a transaction-level model of
// the operand entry sequence and a behavioural lab ALU.
module tb_alu_operand_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic [3:0] data_in;
    logic       step_in;
    logic       chain;
    logic [3:0] alu_result;
    logic [3:0] op_a, op_b, result;
    logic [2:0] opcode, state;
    logic       done;
    logic [7:0] op_count;

    logic [3:0] alu_result2;
    logic [3:0] op_a2, op_b2, result2;
    logic [2:0] opcode2, state2;
    logic       done2;
    logic [1:0] op_count2;

    int compared   = 0;
    int mismatched = 0;

    // Transaction-level expectations
    logic [3:0] m_a, m_b, m_res;
    logic [2:0] m_op;
    int         m_ops;

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        case (op)
            3'b000:  return ~a;
            3'b001:  return a & b;
            3'b010:  return a | b;
            3'b100:  return a ^ b;
            default: return 4'd0;
        endcase
    endfunction

    assign alu_result  = alu_ref(op_a, op_b, opcode);
    assign alu_result2 = alu_ref(op_a2, op_b2, opcode2);

    alu_operand_sequencer #(.WIDTH(4), .COUNT_W(8)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .data_in(data_in), .step_in(step_in),
        .chain(chain), .alu_result(alu_result), .op_a(op_a), .op_b(op_b),
        .opcode(opcode), .result(result), .done(done), .state(state),
        .op_count(op_count)
    );

    alu_operand_sequencer #(.WIDTH(4), .COUNT_W(2)) dut_small (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .data_in(data_in), .step_in(step_in),
        .chain(chain), .alu_result(alu_result2), .op_a(op_a2), .op_b(op_b2),
        .opcode(opcode2), .result(result2), .done(done2), .state(state2),
        .op_count(op_count2)
    );

    function automatic logic [26:0] obs();
        return {op_a, op_b, opcode, result, done, state, op_count};
    endfunction

    function automatic logic [26:0] expv(input logic [2:0] st, input logic dn);
        logic [7:0] cnt;
        cnt = 8'(m_ops % 256);
        return {m_a, m_b, m_op, m_res, dn, st, cnt};
    endfunction

    function automatic logic [6:0] obs_small();
        return {result2, done2, op_count2};
    endfunction

    function automatic logic [6:0] exp_small(input logic dn);
        logic [1:0] cnt;
        cnt = 2'(m_ops % 4);
        return {m_res, dn, cnt};
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_ops = 0;
    endtask

    task automatic press(input logic [3:0] v, input logic ch);
        @(negedge CLOCK_50);
        data_in = v;
        chain   = ch;
        step_in = 1'b1;
        @(negedge CLOCK_50);
        step_in = 1'b0;
        data_in = 4'($urandom);
        chain   = 1'($urandom);
    endtask

    task automatic enter_a(input logic [3:0] v);
        press(v, 1'($urandom));
        m_a = v;
        compared++;
        if (obs() !== expv(3'd1, 1'b0)) begin
            mismatched++;
            $display("FAIL enter_a: observed %h required %h", obs(), expv(3'd1, 1'b0));
        end
    endtask

    task automatic enter_b(input logic [3:0] v);
        press(v, 1'($urandom));
        m_b = v;
        compared++;
        if (obs() !== expv(3'd2, 1'b0)) begin
            mismatched++;
            $display("FAIL enter_b: observed %h required %h", obs(), expv(3'd2, 1'b0));
        end
    endtask

    task automatic enter_op(input logic [3:0] v);
        press(v, 1'($urandom));
        m_op = v[2:0];
        compared++;
        if (obs() !== expv(3'd3, 1'b0)) begin
            mismatched++;
            $display("FAIL enter_op: observed %h required %h", obs(), expv(3'd3, 1'b0));
        end
        @(negedge CLOCK_50);
        m_res = alu_ref(m_a, m_b, m_op);
        m_ops++;
        compared++;
        if (obs() !== expv(3'd4, 1'b1)) begin
            mismatched++;
            $display("FAIL exec_capture: observed %h required %h", obs(), expv(3'd4, 1'b1));
        end
        compared++;
        if (obs_small() !== exp_small(1'b1)) begin
            mismatched++;
            $display("FAIL small_capture: observed %h required %h", obs_small(), exp_small(1'b1));
        end
        @(negedge CLOCK_50);
        compared++;
        if (obs() !== expv(3'd4, 1'b0)) begin
            mismatched++;
            $display("FAIL done_width: observed %h required %h", obs(), expv(3'd4, 1'b0));
        end
    endtask

    task automatic leave_show(input logic ch);
        press(4'($urandom), ch);
        if (ch) m_a = m_res;
        compared++;
        if (obs() !== expv(ch ? 3'd1 : 3'd0, 1'b0)) begin
            mismatched++;
            $display("FAIL leave_show: observed %h required %h", obs(), expv(ch ? 3'd1 : 3'd0, 1'b0));
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step_in = 1'b1;
        data_in = 4'hF;
        repeat (3) @(negedge CLOCK_50);
        model_reset();
        compared++;
        if (obs() !== expv(3'd0, 1'b0)) begin
            mismatched++;
            $display("FAIL reset_state: observed %h required %h", obs(), expv(3'd0, 1'b0));
        end
        step_in = 1'b0;
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        compared++;
        if (obs() !== expv(3'd0, 1'b0)) begin
            mismatched++;
            $display("FAIL reset_idle: observed %h required %h", obs(), expv(3'd0, 1'b0));
        end
    endtask

    task automatic test_basic();
        enter_a(4'd6);
        enter_b(4'd5);
        enter_op(4'd0);
        compared++;
        if (result !== 4'b1001 || op_count !== 8'd1) begin
            mismatched++;
            $display("FAIL basic_not: observed res=%h cnt=%0d required res=9 cnt=1", result, op_count);
        end
    endtask

    task automatic test_opcodes();
        logic [2:0] ops [4] = '{3'b001, 3'b010, 3'b100, 3'b011};
        logic [3:0] res [4] = '{4'd4, 4'd7, 4'd3, 4'd0};
        for (int i = 0; i < 4; i++) begin
            leave_show(1'b0);
            enter_a(4'd6);
            enter_b(4'd5);
            // Upper switch bit set to show it is ignored for the opcode.
            enter_op({1'b1, ops[i]});
            compared++;
            if (result !== res[i]) begin
                mismatched++;
                $display("FAIL opcode_%0d: observed %h required %h", i, result, res[i]);
            end
        end
        compared++;
        if (op_count !== 8'd5) begin
            mismatched++;
            $display("FAIL opcode_count: observed %0d required 5", op_count);
        end
    endtask

    task automatic test_chain();
        leave_show(1'b0);
        enter_a(4'd6);
        enter_b(4'd5);
        enter_op(4'd0);
        leave_show(1'b1);
        compared++;
        if (op_a !== 4'd9 || state !== 3'd1) begin
            mismatched++;
            $display("FAIL chain_reuse: observed a=%h st=%0d required a=9 st=1", op_a, state);
        end
        enter_b(4'd5);
        enter_op(4'd1);
        compared++;
        if (result !== 4'b0001) begin
            mismatched++;
            $display("FAIL chain_and: observed %h required 1", result);
        end
    endtask

    task automatic test_held_step();
        leave_show(1'b0);
        @(negedge CLOCK_50);
        data_in = 4'd3;
        step_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            data_in = 4'($urandom);
        end
        m_a = 4'd3;
        step_in = 1'b0;
        compared++;
        if (obs() !== expv(3'd1, 1'b0)) begin
            mismatched++;
            $display("FAIL held_step: observed %h required %h", obs(), expv(3'd1, 1'b0));
        end
        enter_b(4'($urandom));
        // Opcode press with the button kept down through the execute cycle.
        @(negedge CLOCK_50);
        data_in = 4'd2;
        step_in = 1'b1;
        @(negedge CLOCK_50);
        m_op = 3'd2;
        @(negedge CLOCK_50);
        step_in = 1'b0;
        m_res = alu_ref(m_a, m_b, m_op);
        m_ops++;
        compared++;
        if (obs() !== expv(3'd4, 1'b1)) begin
            mismatched++;
            $display("FAIL exec_held: observed %h required %h", obs(), expv(3'd4, 1'b1));
        end
        repeat (3) @(negedge CLOCK_50);
        compared++;
        if (obs() !== expv(3'd4, 1'b0)) begin
            mismatched++;
            $display("FAIL exec_no_queue: observed %h required %h", obs(), expv(3'd4, 1'b0));
        end
    endtask

    task automatic test_reset_mid();
        leave_show(1'b0);
        enter_a(4'($urandom));
        enter_b(4'($urandom));
        @(negedge CLOCK_50);
        data_in = 4'd1;
        step_in = 1'b1;
        RESET   = 1'b1;
        @(negedge CLOCK_50);
        model_reset();
        compared++;
        if (obs() !== expv(3'd0, 1'b0)) begin
            mismatched++;
            $display("FAIL reset_in_op: observed %h required %h", obs(), expv(3'd0, 1'b0));
        end
        RESET   = 1'b0;
        step_in = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        compared++;
        if (obs() !== expv(3'd0, 1'b0) || obs_small() !== exp_small(1'b0)) begin
            mismatched++;
            $display("FAIL reset_no_done: observed %h required %h", obs(), expv(3'd0, 1'b0));
        end
    endtask

    task automatic test_count_wrap();
        logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            enter_a(4'($urandom));
            enter_b(4'($urandom));
            enter_op(4'($urandom));
            compared++;
            if (op_count2 !== seq[i]) begin
                mismatched++;
                $display("FAIL count_wrap_%0d: observed %0d required %0d", i, op_count2, seq[i]);
            end
            leave_show(1'b0);
        end
    endtask

    task automatic test_random();
        logic ch;
        ch = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!ch) enter_a(4'($urandom));
            enter_b(4'($urandom));
            enter_op(4'($urandom));
            ch = 1'($urandom);
            leave_show(ch);
        end
    endtask

    initial begin
        RESET   = 1'b1;
        step_in = 1'b0;
        data_in = 4'd0;
        chain   = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_opcodes();
        test_chain();
        test_held_step();
        test_reset_mid();
        test_count_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
